hsv_seq_ctrl: RTL and testbench



---
 rtl/hsv_ctrl_pkg.sv | 16 +
 rtl/hsv_pix_counter.sv | 38 +++
 rtl/hsv_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_hsv_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hsv_ctrl_pkg.sv
// rtl/hsv_ctrl_pkg.sv - shared state encoding and constants for the RGB->HSV sequencer
package hsv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CMP,
    DLT,
    TRI,
    DONE
  } hsv_state_e;

  localparam logic [2:0] TRI_ALL  = 3'b111;
  localparam int         PIPE_LAT = 5;

endpackage

// File: rtl/hsv_pix_counter.sv
// rtl/hsv_pix_counter.sv - wrapping pixel-in-frame counter with last-pixel flag
module hsv_pix_counter #(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pix_cnt = cnt_q;
  assign at_last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/hsv_seq_ctrl.sv
// rtl/hsv_seq_ctrl.sv - handshaked five-step sequencer for the RGB->HSV datapath
// Optional perf counters under HSV_CTRL_PERF_EN.
module hsv_seq_ctrl
  import hsv_ctrl_pkg::*;
#(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_En,
  output logic             S0,
  output logic             Cmax_En,
  output logic             Cmin_En,
  output logic             delta_En,
  output logic [2:0]       tri_En,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] pix_cnt
`ifdef HSV_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_busy,
  output logic [31:0]      perf_stall
`endif
);

  hsv_state_e state_q, state_d;
  logic       pix_inc;
  logic       at_last;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    load_En   = 1'b0;
    S0        = 1'b0;
    Cmax_En   = 1'b0;
    Cmin_En   = 1'b0;
    delta_En  = 1'b0;
    tri_En    = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !clr;
        if (in_valid && !clr) begin
          load_En = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        S0      = 1'b1;
        state_d = CMP;
      end
      CMP: begin
        Cmax_En = 1'b1;
        Cmin_En = 1'b1;
        state_d = DLT;
      end
      DLT: begin
        delta_En = 1'b1;
        state_d  = TRI;
      end
      TRI: begin
        tri_En  = TRI_ALL;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !clr;
        // Chain straight into the next pixel so back-to-back frames see no bubble.
        if (out_ready) begin
          if (in_valid && !clr) begin
            load_En = 1'b1;
            state_d = SEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pix_inc  = out_valid && out_ready && !clr;
  assign out_last = out_valid && at_last;

  hsv_pix_counter #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .CNT_W        (CNT_W)
  ) u_pix_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (pix_inc),
    .clr     (clr),
    .pix_cnt (pix_cnt),
    .at_last (at_last)
  );

`ifdef HSV_CTRL_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  // Saturating so a long-running frame never wraps back to a small count.
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (clr) begin
      busy_d  = '0;
      stall_d = '0;
    end else begin
      if ((state_q != IDLE) && (busy_q != '1)) begin
        busy_d = busy_q + 32'd1;
      end
      if ((state_q == DONE) && !out_ready && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_hsv_seq_ctrl.sv
// tb/tb_hsv_seq_ctrl.sv - self-checking bench for hsv_seq_ctrl against a pixel-age reference model
module tb_hsv_seq_ctrl;

  localparam int FP_A = 307200;
  localparam int FP_B = 3;
  localparam int FP_C = 1;
  localparam int LAT  = 5;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid, out_ready;

  logic        in_ready, load_En, S0, Cmax_En, Cmin_En, delta_En, out_valid, out_last;
  logic [2:0]  tri_En;
  logic [18:0] pix_cnt;
  logic        in_ready3, load_En3, S03, Cmax_En3, Cmin_En3, delta_En3, out_valid3, out_last3;
  logic [2:0]  tri_En3;
  logic [1:0]  pix_cnt3;
  logic        in_ready1, load_En1, S01, Cmax_En1, Cmin_En1, delta_En1, out_valid1, out_last1;
  logic [2:0]  tri_En1;
  logic [0:0]  pix_cnt1;
`ifdef HSV_CTRL_PERF_EN
  logic [31:0] perf_busy, perf_stall, perf_busy3, perf_stall3, perf_busy1, perf_stall1;
`endif

  always #5 clk = ~clk;

  hsv_seq_ctrl #(.FRAME_PIXELS(FP_A), .CNT_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .load_En(load_En), .S0(S0), .Cmax_En(Cmax_En), .Cmin_En(Cmin_En), .delta_En(delta_En),
    .tri_En(tri_En), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .pix_cnt(pix_cnt)
`ifdef HSV_CTRL_PERF_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  hsv_seq_ctrl #(.FRAME_PIXELS(FP_B), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready3),
    .load_En(load_En3), .S0(S03), .Cmax_En(Cmax_En3), .Cmin_En(Cmin_En3), .delta_En(delta_En3),
    .tri_En(tri_En3), .out_valid(out_valid3), .out_ready(out_ready), .out_last(out_last3),
    .pix_cnt(pix_cnt3)
`ifdef HSV_CTRL_PERF_EN
    , .perf_busy(perf_busy3), .perf_stall(perf_stall3)
`endif
  );

  hsv_seq_ctrl #(.FRAME_PIXELS(FP_C), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .load_En(load_En1), .S0(S01), .Cmax_En(Cmax_En1), .Cmin_En(Cmin_En1), .delta_En(delta_En1),
    .tri_En(tri_En1), .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .pix_cnt(pix_cnt1)
`ifdef HSV_CTRL_PERF_EN
    , .perf_busy(perf_busy1), .perf_stall(perf_stall1)
`endif
  );

  // Model: age = cycles since the pixel was accepted (0 = no pixel held, LAT = result shown).
  int          age;
  int          hs;
  longint      busy_m, stall_m;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    age = 0; hs = 0; busy_m = 0; stall_m = 0;
  endtask

  task automatic check_all();
    logic       e_ir, e_ld, e_ov;
    logic [9:0] e_ctl;
    e_ir  = clr ? 1'b0 : (age == 0) ? 1'b1 : (age == LAT) ? out_ready : 1'b0;
    e_ld  = e_ir && in_valid;
    e_ov  = (age == LAT);
    e_ctl = {e_ir, e_ld, age == 1, age == 2, age == 2, age == 3,
             (age == 4) ? 3'b111 : 3'b000, e_ov};
    chk("ctl_a", 32'({in_ready, load_En, S0, Cmax_En, Cmin_En, delta_En, tri_En, out_valid}), 32'(e_ctl));
    chk("ctl_b", 32'({in_ready3, load_En3, S03, Cmax_En3, Cmin_En3, delta_En3, tri_En3, out_valid3}), 32'(e_ctl));
    chk("ctl_c", 32'({in_ready1, load_En1, S01, Cmax_En1, Cmin_En1, delta_En1, tri_En1, out_valid1}), 32'(e_ctl));
    chk("pix_a",  32'(pix_cnt),  32'(hs % FP_A));
    chk("pix_b",  32'(pix_cnt3), 32'(hs % FP_B));
    chk("pix_c",  32'(pix_cnt1), 32'(hs % FP_C));
    chk("last_a", 32'(out_last),  32'(e_ov && (hs % FP_A == FP_A - 1)));
    chk("last_b", 32'(out_last3), 32'(e_ov && (hs % FP_B == FP_B - 1)));
    chk("last_c", 32'(out_last1), 32'(e_ov && (hs % FP_C == FP_C - 1)));
`ifdef HSV_CTRL_PERF_EN
    chk("busy",  perf_busy,  32'(busy_m));
    chk("stall", perf_stall, 32'(stall_m));
    chk("busy_b", perf_busy3, 32'(busy_m));
    chk("stall_c", perf_stall1, 32'(stall_m));
`endif
  endtask

  task automatic model_step(input bit iv, input bit ordy, input bit c);
    if (c) begin
      busy_m = 0; stall_m = 0; age = 0; hs = 0;
    end else begin
      if (age != 0) busy_m++;
      if (age == LAT && !ordy) stall_m++;
      if (age == 0) begin
        if (iv) age = 1;
      end else if (age < LAT) begin
        age++;
      end else if (ordy) begin
        hs++;
        age = iv ? 1 : 0;
      end
    end
  endtask

  // Called at posedge+1; checks just before the following edge, then advances the model.
  task automatic cycle(input bit iv, input bit ordy, input bit c);
    in_valid = iv; out_ready = ordy; clr = c;
    #3;
    check_all();
    @(posedge clk); #1;
    cyc++;
    model_step(iv, ordy, c);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single pixel
    cycle(1, 1, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0);

    // back-to-back, four pixels
    for (int i = 0; i < 4 * LAT; i++) cycle(1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // backpressure: seven stalled cycles in DONE
    cycle(0, 1, 1);
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0);
`ifdef HSV_CTRL_PERF_EN
    chk("stall7", perf_stall, 32'd7);
`endif
    chk("bp_valid", 32'(out_valid), 32'd1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // frame wrap across several pixels
    for (int p = 0; p < 4; p++) begin
      cycle(1, 1, 0);
      for (int i = 0; i < LAT; i++) cycle(0, 1, 0);
    end

    // clr in CMP, then clr coinciding with in_valid
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // asynchronous reset while in TRI
    cycle(1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    chk("in_tri", 32'(tri_En), 32'd7);
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
